// File: rtl/ahb_dtcm_bridge.sv
// AHB-Lite slave into the shared DTCM port; yields to the core data port and DMA every cycle.
// Build option: define AHB_DTCM_ALIGN_CHECK_EN to reject unaligned or oversized transfers with ERROR.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ahb_dtcm_bridge (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   HSEL,
    input  logic [`ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [`DATA_WIDTH-1:0] HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [`DATA_WIDTH-1:0] HRDATA,
    input  logic                   data_dtcm_access,
    input  logic                   dma_dtcm_access,
    output logic                   AHB_dtcm_access,
    output logic                   AHB_tcm_rd0_wr1,
    output logic [3:0]             AHB_tcm_byte_strobe,
    output logic [`ADDR_WIDTH-1:0] AHB_tcm_addr,
    output logic [`DATA_WIDTH-1:0] AHB_tcm_wdata,
    input  logic [`DATA_WIDTH-1:0] AHB_dtcm_rdata,
    input  logic                   AHB_dtcm_rdata_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [`ADDR_WIDTH-1:0] r_addr;
    logic                   r_write;
    logic [2:0]             r_size;

    logic w_grant;
    logic w_req;
    logic w_bad;
    logic w_open;
    logic w_accept;

    assign w_grant = !data_dtcm_access & !dma_dtcm_access;
    assign w_req   = HSEL & HTRANS[1] & HREADY;

`ifdef AHB_DTCM_ALIGN_CHECK_EN
    assign w_bad = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
    assign w_bad = 1'b0;
`endif

    // w_open marks the cycle in which the current data phase completes and a new address phase may be taken
    always_comb begin
        w_next          = r_state;
        w_open          = 1'b0;
        HREADYOUT       = 1'b1;
        HRESP           = 1'b0;
        AHB_dtcm_access = 1'b0;
        AHB_tcm_rd0_wr1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_open = 1'b1;
            end
            S_WR: begin
                if (w_grant) begin
                    AHB_dtcm_access = 1'b1;
                    AHB_tcm_rd0_wr1 = 1'b1;
                    w_open          = 1'b1;
                end else begin
                    HREADYOUT = 1'b0;
                end
            end
            S_RD_REQ: begin
                HREADYOUT = 1'b0;
                if (w_grant) begin
                    AHB_dtcm_access = 1'b1;
                    w_next          = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (AHB_dtcm_rdata_valid) begin
                    w_open = 1'b1;
                end else begin
                    HREADYOUT = 1'b0;
                    w_next    = S_RD_REQ;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                HRESP  = 1'b1;
                w_open = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_accept = w_open & w_req;
        if (w_open) begin
            if (!w_req)
                w_next = S_IDLE;
            else if (w_bad)
                w_next = S_ERR1;
            else if (HWRITE)
                w_next = S_WR;
            else
                w_next = S_RD_REQ;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    always_comb begin
        AHB_tcm_byte_strobe = 4'b1111;
        if (r_write) begin
            case (r_size)
                3'd0:    AHB_tcm_byte_strobe = 4'b0001 << r_addr[1:0];
                3'd1:    AHB_tcm_byte_strobe = r_addr[1] ? 4'b1100 : 4'b0011;
                default: AHB_tcm_byte_strobe = 4'b1111;
            endcase
        end
    end

    assign AHB_tcm_addr  = r_addr;
    assign AHB_tcm_wdata = HWDATA;
    assign HRDATA        = AHB_dtcm_rdata;

endmodule

// File: tb/tb_ahb_dtcm_bridge.sv
// Self-checking bench for ahb_dtcm_bridge: table-driven AHB transfers against a byte-lane TCM model,
// with a write scoreboard popped on TCM write strobes and a read scoreboard popped on data-phase completion.
module tb_ahb_dtcm_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        data_dtcm_access;
    logic        dma_dtcm_access;
    logic        AHB_dtcm_access;
    logic        AHB_tcm_rd0_wr1;
    logic [3:0]  AHB_tcm_byte_strobe;
    logic [31:0] AHB_tcm_addr;
    logic [31:0] AHB_tcm_wdata;
    logic [31:0] AHB_dtcm_rdata       = '0;
    logic        AHB_dtcm_rdata_valid = 1'b0;

    logic        hready_low;
    logic        drop_valid;
    assign HREADY = HREADYOUT & ~hready_low;

    ahb_dtcm_bridge dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .HSEL                 (HSEL),
        .HADDR                (HADDR),
        .HTRANS               (HTRANS),
        .HWRITE               (HWRITE),
        .HSIZE                (HSIZE),
        .HWDATA               (HWDATA),
        .HREADY               (HREADY),
        .HREADYOUT            (HREADYOUT),
        .HRESP                (HRESP),
        .HRDATA               (HRDATA),
        .data_dtcm_access     (data_dtcm_access),
        .dma_dtcm_access      (dma_dtcm_access),
        .AHB_dtcm_access      (AHB_dtcm_access),
        .AHB_tcm_rd0_wr1      (AHB_tcm_rd0_wr1),
        .AHB_tcm_byte_strobe  (AHB_tcm_byte_strobe),
        .AHB_tcm_addr         (AHB_tcm_addr),
        .AHB_tcm_wdata        (AHB_tcm_wdata),
        .AHB_dtcm_rdata       (AHB_dtcm_rdata),
        .AHB_dtcm_rdata_valid (AHB_dtcm_rdata_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wexp_t;

    wexp_t       wq[$];
    logic [31:0] rq[$];

    // TCM model: command sampled mid-cycle, applied on the next rising edge
    logic [31:0] mem [0:1023];
    logic        mem_ready = 1'b0;
    logic        p_acc = 1'b0;
    logic        p_wr  = 1'b0;
    logic [3:0]  p_strb = '0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    int          tcm_acc_cnt = 0;

    always begin
        @(negedge clk);
        #1;
        p_acc  = AHB_dtcm_access;
        p_wr   = AHB_tcm_rd0_wr1;
        p_strb = AHB_tcm_byte_strobe;
        p_addr = AHB_tcm_addr;
        p_data = AHB_tcm_wdata;
        if (data_dtcm_access || dma_dtcm_access)
            check("no_cmd_without_grant", {30'b0, AHB_dtcm_access, AHB_tcm_rd0_wr1}, 32'h0);
        if (AHB_dtcm_access) begin
            tcm_acc_cnt++;
            if (AHB_tcm_rd0_wr1) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write to 0x%08h, required no write", AHB_tcm_addr);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    check("wr_addr", AHB_tcm_addr, e.addr);
                    check("wr_strobe", 32'(AHB_tcm_byte_strobe), 32'(e.strb));
                    check("wr_data", AHB_tcm_wdata, e.data);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (p_acc && p_wr) begin
            for (int b = 0; b < 4; b++)
                if (p_strb[b]) mem[p_addr[11:2]][8*b +: 8] <= p_data[8*b +: 8];
        end
        AHB_dtcm_rdata_valid <= p_acc && !p_wr && !drop_valid;
        if (p_acc && !p_wr) AHB_dtcm_rdata <= mem[p_addr[11:2]];
    end

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  strb;
        int          waits;
        logic        resp;
        int          st_start;
        int          st_len;
        logic        st_dma;
        int          drop_at;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic [3:0] strb,
                                input int waits, input logic resp, input int st_start, input int st_len,
                                input logic st_dma, input int drop_at);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.strb = strb;
        v.waits = waits; v.resp = resp; v.st_start = st_start; v.st_len = st_len;
        v.st_dma = st_dma; v.drop_at = drop_at;
        return v;
    endfunction

    task automatic xfer(input vec_t v);
        int          k;
        int          base;
        logic        done;
        logic        stall;
        logic [31:0] exp_rd;
        base = tcm_acc_cnt;
        if (!v.resp) begin
            if (v.wr) wq.push_back({v.addr, v.strb, v.wdata});
            else      rq.push_back(v.rdata);
        end
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size;
        k = 0;
        done = 1'b0;
        while (!done && k < 32) begin
            @(negedge clk);
            if (k == 0) begin
                HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
                HWDATA = v.wr ? v.wdata : 32'h0;
            end
            stall = (k >= v.st_start) && (k < v.st_start + v.st_len);
            data_dtcm_access = stall && !v.st_dma;
            dma_dtcm_access  = stall && v.st_dma;
            drop_valid       = (k == v.drop_at);
            #1;
            if (HREADYOUT) done = 1'b1;
            else begin
                if (k == 0) check("resp_in_wait", 32'(HRESP), 32'(v.resp));
                k++;
            end
        end
        data_dtcm_access = 1'b0;
        dma_dtcm_access  = 1'b0;
        drop_valid       = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no HREADYOUT after %0d cycles, required completion", k);
            return;
        end
        check("wait_states", 32'(k), 32'(v.waits));
        check("hresp", 32'(HRESP), 32'(v.resp));
        if (!v.wr && !v.resp && rq.size() != 0) begin
            exp_rd = rq.pop_front();
            check("hrdata", HRDATA, exp_rd);
        end
        if (v.resp) check("err_no_tcm_access", 32'(tcm_acc_cnt - base), 32'h0);
    endtask

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required $finish");
        $fatal(1);
    end

    initial begin
        int base;
        rstn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = '0; HWDATA = '0;
        hready_low = 1'b0; data_dtcm_access = 1'b0; dma_dtcm_access = 1'b0; drop_valid = 1'b0;

        //            wr  sz    addr          wdata         rdata         strb     wt rsp  st sl dma drop
        vecs[0]  = mk(1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4'b1111, 0, 0, 0, 0, 0, -1);
        vecs[1]  = mk(0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 4'b0,   1, 0, 0, 0, 0, -1);
        vecs[2]  = mk(1, 3'd0, 32'h0000_0103, 32'hAA00_0000, 32'h0,        4'b1000, 0, 0, 0, 0, 0, -1);
        vecs[3]  = mk(1, 3'd1, 32'h0000_0102, 32'h5566_0000, 32'h0,        4'b1100, 0, 0, 0, 0, 0, -1);
        vecs[4]  = mk(0, 3'd2, 32'h0000_0100, 32'h0,         32'h5566_BEEF, 4'b0,   1, 0, 0, 0, 0, -1);
        vecs[5]  = mk(1, 3'd0, 32'h0000_0200, 32'h0000_0011, 32'h0,        4'b0001, 0, 0, 0, 0, 0, -1);
        vecs[6]  = mk(1, 3'd0, 32'h0000_0201, 32'h0000_2200, 32'h0,        4'b0010, 0, 0, 0, 0, 0, -1);
        vecs[7]  = mk(1, 3'd1, 32'h0000_0204, 32'h0000_CAFE, 32'h0,        4'b0011, 0, 0, 0, 0, 0, -1);
        vecs[8]  = mk(0, 3'd2, 32'h0000_0200, 32'h0,         32'h0000_2211, 4'b0,   1, 0, 0, 0, 0, -1);
        vecs[9]  = mk(0, 3'd2, 32'h0000_0204, 32'h0,         32'h0000_CAFE, 4'b0,   1, 0, 0, 0, 0, -1);
        vecs[10] = mk(1, 3'd2, 32'h0000_0104, 32'h0BAD_F00D, 32'h0,        4'b1111, 3, 0, 0, 3, 0, -1);
        vecs[11] = mk(0, 3'd2, 32'h0000_0104, 32'h0,         32'h0BAD_F00D, 4'b0,   4, 0, 1, 2, 0, 0);
`ifdef AHB_DTCM_ALIGN_CHECK_EN
        vecs[12] = mk(1, 3'd3, 32'h0000_0208, 32'h1234_5678, 32'h0,        4'b1111, 1, 1, 0, 0, 0, -1);
        vecs[13] = mk(0, 3'd2, 32'h0000_0102, 32'h0,         32'h0,        4'b0,    1, 1, 0, 0, 0, -1);
        vecs[15] = mk(0, 3'd2, 32'h0000_0208, 32'h0,         32'h0,        4'b0,    1, 0, 0, 0, 0, -1);
`else
        vecs[12] = mk(1, 3'd3, 32'h0000_0208, 32'h1234_5678, 32'h0,        4'b1111, 0, 0, 0, 0, 0, -1);
        vecs[13] = mk(0, 3'd2, 32'h0000_0102, 32'h0,         32'h5566_BEEF, 4'b0,   1, 0, 0, 0, 0, -1);
        vecs[15] = mk(0, 3'd2, 32'h0000_0208, 32'h0,         32'h1234_5678, 4'b0,   1, 0, 0, 0, 0, -1);
`endif
        vecs[14] = mk(1, 3'd2, 32'h0000_010C, 32'hA5A5_A5A5, 32'h0,        4'b1111, 1, 0, 0, 1, 1, -1);

        repeat (3) @(negedge clk);
        #1;
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_hresp", 32'(HRESP), 32'h0);
        check("rst_tcm_access", 32'(AHB_dtcm_access), 32'h0);
        check("rst_tcm_addr", AHB_tcm_addr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) xfer(vecs[i]);

        // pipelined write followed by read: read address phase overlaps the write data phase
        wq.push_back({32'h0000_0400, 4'b1111, 32'h1357_9BDF});
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0400; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge clk);
        HWDATA = 32'h1357_9BDF; HWRITE = 1'b0;
        #1 check("pipe_wr_ready", 32'(HREADYOUT), 32'h1);
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        #1 check("pipe_rd_wait", 32'(HREADYOUT), 32'h0);
        @(negedge clk);
        #1;
        check("pipe_rd_ready", 32'(HREADYOUT), 32'h1);
        check("pipe_rd_data", HRDATA, 32'h1357_9BDF);
        check("pipe_rd_resp", 32'(HRESP), 32'h0);

        // HREADY low and non-active HTRANS must not start a transfer
        base = tcm_acc_cnt;
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h0000_0500; hready_low = 1'b1;
        #1 check("hready_low_idle", 32'(HREADYOUT), 32'h1);
        @(negedge clk);
        hready_low = 1'b0; HTRANS = 2'b01; HWDATA = 32'hFFFF_FFFF;
        #1 check("busy_ready", 32'(HREADYOUT), 32'h1);
        check("busy_resp", 32'(HRESP), 32'h0);
        @(negedge clk);
        HTRANS = 2'b00;
        #1 check("idle_ready", 32'(HREADYOUT), 32'h1);
        @(negedge clk);
        HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0;
        #1 check("idle_after_busy_ready", 32'(HREADYOUT), 32'h1);
        check("no_access_when_not_sampled", 32'(tcm_acc_cnt - base), 32'h0);
        xfer(mk(0, 3'd2, 32'h0000_0500, 32'h0, 32'h0, 4'b0, 1, 0, 0, 0, 0, -1));

        // asynchronous reset while a write is stalled by the core
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0300; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = 32'h7777_7777;
        data_dtcm_access = 1'b1;
        #1 check("rst_wr_stalled", 32'(HREADYOUT), 32'h0);
        #2;
        rstn = 1'b0;
        data_dtcm_access = 1'b0;
        #1;
        check("rst_mid_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_mid_access", 32'(AHB_dtcm_access), 32'h0);
        check("rst_mid_addr", AHB_tcm_addr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        xfer(mk(0, 3'd2, 32'h0000_0300, 32'h0, 32'h0, 4'b0, 1, 0, 0, 0, 0, -1));

        repeat (2) @(negedge clk);
        #1;
        check("write_scoreboard_empty", 32'(wq.size()), 32'h0);
        check("read_scoreboard_empty", 32'(rq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
